// File: rtl/direct_mapped_cache.sv
// Direct-mapped, read-only, word-addressed cache. It sits between the CPU load path and DataMemory.
// On a miss it fetches a four-word block after a fixed memory latency.
module direct_mapped_cache #(
  parameter int INDEX_BITS  = 10,
  parameter int MEM_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [14:0]  req_addr,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [31:0]  resp_data,
  output logic         resp_hit,
  output logic [14:0]  mem_address,
  input  logic [127:0] mem_data,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int TAG_BITS = 13 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    MEM_WAIT
  } state_t;

  state_t               state;
  logic [14:0]          addr_q;
  logic [CNT_W-1:0]     wait_cnt;
  logic [LINES-1:0]     valid_q;
  logic [127:0]         data_mem [LINES];
  logic [TAG_BITS-1:0]  tag_mem  [LINES];

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [1:0]            req_off;
  logic [127:0]          line_data;
  logic                  hit;
  logic                  refill_done;

  assign req_tag     = addr_q[14:2+INDEX_BITS];
  assign req_index   = addr_q[1+INDEX_BITS:2];
  assign req_off     = addr_q[1:0];
  assign line_data   = data_mem[req_index];
  assign hit         = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign refill_done = (state == MEM_WAIT) && (wait_cnt == '0);

  // Offset 0 is the most significant word, both in mem_data and in the line.
  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] off);
    logic [31:0] w;
    w = blk[127:96];
    case (off)
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      2'd3:    w = blk[31:0];
      default: w = blk[127:96];
    endcase
    return w;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wait_cnt    <= '0;
      valid_q     <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_data   <= '0;
      mem_address <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_data  <= word_sel(line_data, req_off);
            hit_count  <= sat_inc(hit_count);
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            mem_address <= {addr_q[14:2], 2'b00};
            wait_cnt    <= CNT_W'(MEM_LATENCY - 1);
            miss_count  <= sat_inc(miss_count);
            state       <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end else begin
            valid_q[req_index] <= 1'b1;
            resp_valid         <= 1'b1;
            resp_hit           <= 1'b0;
            resp_data          <= word_sel(mem_data, req_off);
            req_ready          <= 1'b1;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the data and tag arrays have no reset; the valid vector alone decides
  // whether a line is usable, which keeps the arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      data_mem[req_index] <= mem_data;
      tag_mem[req_index]  <= req_tag;
    end
  end

endmodule

// File: doc/direct_mapped_cache.md
Name: direct_mapped_cache

Overview:
- Direct-mapped, read-only, word-addressed cache between the CPU load path and DataMemory.
- Services single-word reads from a CPU request port.
- On a miss, drives a block-aligned 15-bit address to DataMemory, waits a fixed latency, then captures the 128-bit four-word block into the line.
- Keeps saturating hit and miss counters for performance measurement.

Parameters:
- INDEX_BITS, 10, line index width; 2**INDEX_BITS lines of 4 words; tag width = 13 - INDEX_BITS (legal range 1..12).
- MEM_LATENCY, 4, cycles mem_data must settle after mem_address changes; minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  CPU read request.
- req_addr  input  15  word address: [14:2+INDEX_BITS] tag, [1+INDEX_BITS:2] index, [1:0] word offset.
- req_ready  output  1  high when a request can be accepted.
- resp_valid  output  1  one-cycle pulse, read data valid.
- resp_data  output  32  read word.
- resp_hit  output  1  qualifies resp_valid: 1 = hit, 0 = serviced by refill.
- mem_address  output  15  block address to DataMemory, low 2 bits always 0.
- mem_data  input  128  block from DataMemory; word at mem_address is [127:96], +1 is [95:64], +2 is [63:32], +3 is [31:0].
- hit_count  output  16  saturating hit counter.
- miss_count  output  16  saturating miss counter.

Behaviour:
- Reset (async): state IDLE, all line valid bits 0, req_ready 1, resp_valid 0, resp_hit 0, resp_data 0, mem_address 0, both counters 0. Data and tag arrays are not cleared.
- States:
  - IDLE: req_ready = 1. On a clock edge with req_valid=1, latch req_addr and go to COMPARE. Otherwise req_valid is ignored.
  - COMPARE: req_ready = 0. Hit = valid[index] and tag match.
    - Hit: at the next edge assert resp_valid=1, resp_hit=1, resp_data = selected word; hit_count++; go to IDLE.
    - Miss: at the next edge set mem_address = {tag, index, 2'b00}, load the wait counter with MEM_LATENCY-1; miss_count++; go to MEM_WAIT.
  - MEM_WAIT: req_ready = 0; mem_address held.
    - Counter nonzero: decrement at each edge.
    - Counter zero: at that edge write mem_data into the line, set the tag and valid[index]=1, assert resp_valid=1, resp_hit=0, resp_data = word selected by offset from mem_data; go to IDLE.
- Latency, request accepted at edge N:
  - Hit: resp_valid high in the cycle after edge N+1.
  - Miss: resp_valid high in the cycle after edge N+1+MEM_LATENCY.
- resp_valid is exactly one cycle. resp_data and resp_hit hold their last values afterwards.
- Back-to-back: IDLE is re-entered in the same cycle as resp_valid, so a new request may be accepted on the very next edge. No CPU-side stall input exists; the CPU must take the response in its valid cycle.
- Word select: offset 0 → [127:96], 1 → [95:64], 2 → [63:32], 3 → [31:0]. The same mapping applies to line storage.
- Counters stop at 16'hFFFF with no wrap.
- Conflict: a refill to an occupied index overwrites the line unconditionally. Read-only, so no writeback.
- Reset mid-operation (COMPARE or MEM_WAIT): abort immediately. No response is produced, the line is left invalid, and the counters clear.
- A request whose tag matches but whose line is invalid is a miss.

Test Plan:
1. Cold miss: memory preloaded mem[i]=i, MEM_LATENCY=4. Request 0x0012 accepted at edge N → mem_address=0x0010 after edge N+1; resp_valid after edge N+5; resp_data=0x00000012, resp_hit=0, miss_count=1.
2. Hit: then request 0x0013 → resp after edge N+1 with resp_data=0x00000013, resp_hit=1, hit_count=1. Request 0x0010 → 0x00000010, hit.
3. Conflict (INDEX_BITS=10): request 0x1010 (same index, tag 1) → miss, data 0x00001010. Re-request 0x0010 → miss again, data 0x00000010, miss_count=3.
4. Reset mid-miss: assert rst two cycles into MEM_WAIT → req_ready=1 and resp_valid=0 asynchronously, counters 0. Re-request the same address → miss (valid was cleared).
5. Back-to-back: hold req_valid=1 with alternating hit addresses → one accept every 2 cycles, each resp_valid a single-cycle pulse. req_valid pulses while req_ready=0 are ignored, with no extra responses.
6. Saturation: force 65540 hits → hit_count stays 0xFFFF.
